// File: rtl/mux_sel_scanner.sv
// Channel sequencer feeding the 8:1 mux select/data inputs.
// Optional sweep counter output enabled by MUX_SEL_SCANNER_SWEEP_CNT_EN.
module mux_sel_scanner #(
    parameter int N_CH  = 8,
    parameter int DWELL = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_stop,
    input  logic            i_cont,
    input  logic [N_CH-1:0] i_mask,
    input  logic            i_data,
    output logic [N_CH-1:0] o_sel_code,
    output logic            o_a,
    output logic            o_valid,
    output logic [2:0]      o_ch_idx,
    output logic            o_busy,
    output logic            o_done
`ifdef MUX_SEL_SCANNER_SWEEP_CNT_EN
    ,
    output logic [7:0]      o_sweep_cnt
`endif
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mask_q, mask_d;
    logic            cont_q, cont_d;
    logic [2:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            a_q, a_d;
    logic [7:0]      above;
    logic            sweep_end;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Enabled channels strictly above the current one; 2<<7 wraps to 0.
    assign above = mask_q & ~((8'd2 << idx_q) - 8'd1);

    assign sweep_end = (state_q == SCAN) && !i_stop
                     && (cnt_q == LAST) && (above == 8'd0);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start && !i_stop) begin
                    mask_d = i_mask;
                    cont_d = i_cont;
                    if (i_mask != 8'd0) begin
                        state_d = SCAN;
                        idx_d   = lowest(i_mask);
                        cnt_d   = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (i_stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (above != 8'd0) begin
                        idx_d = lowest(above);
                    end else begin
                        done_d = 1'b1;
                        if (cont_q) begin
                            idx_d = lowest(mask_q);
                        end else begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
        a_d = (state_d == SCAN) ? i_data : 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cont_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            a_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            a_q     <= a_d;
        end
    end

`ifdef MUX_SEL_SCANNER_SWEEP_CNT_EN
    logic [7:0] sweep_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sweep_q <= '0;
        end else if (sweep_end) begin
            sweep_q <= sweep_q + 8'd1;
        end
    end

    assign o_sweep_cnt = sweep_q;
`else
    logic unused_sweep;
    assign unused_sweep = sweep_end;
`endif

    assign o_busy     = (state_q == SCAN);
    assign o_valid    = o_busy;
    assign o_sel_code = o_busy ? (8'd1 << idx_q) : 8'd0;
    assign o_ch_idx   = idx_q;
    assign o_a        = a_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Randomized + directed bench for mux_sel_scanner against a
// sweep-position reference model.
module tb_mux_sel_scanner;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst, start, stop, cont, data;
    logic [7:0] mask;
    logic [7:0] sel;
    logic       a, valid, busy, done;
    logic [2:0] idx;
`ifdef MUX_SEL_SCANNER_SWEEP_CNT_EN
    logic [7:0] sweep_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: list of enabled channels and position in sweep.
    int  m_ch[$];
    int  m_pos;
    bit  m_busy, m_cont, m_done, m_a;
    int  m_sweeps;

    always #5 clk = ~clk;

    mux_sel_scanner #(.N_CH(8), .DWELL(DWELL)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_stop     (stop),
        .i_cont     (cont),
        .i_mask     (mask),
        .i_data     (data),
        .o_sel_code (sel),
        .o_a        (a),
        .o_valid    (valid),
        .o_ch_idx   (idx),
        .o_busy     (busy),
        .o_done     (done)
`ifdef MUX_SEL_SCANNER_SWEEP_CNT_EN
        ,
        .o_sweep_cnt(sweep_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        m_done = 0;
        if (rst) begin
            m_busy = 0; m_pos = 0; m_a = 0; m_sweeps = 0;
            m_cont = 0; m_ch.delete();
            return;
        end
        if (!m_busy) begin
            if (start && !stop) begin
                m_ch.delete();
                for (int i = 0; i < 8; i++)
                    if (mask[i]) m_ch.push_back(i);
                m_cont = cont;
                if (m_ch.size() == 0) m_done = 1;
                else begin m_busy = 1; m_pos = 0; end
            end
        end else if (stop) begin
            m_busy = 0;
        end else begin
            m_pos++;
            if (m_pos == m_ch.size() * DWELL) begin
                m_done = 1;
                m_sweeps++;
                m_pos = 0;
                if (!m_cont) m_busy = 0;
            end
        end
        m_a = m_busy ? data : 1'b0;
    endtask

    task automatic check_outputs();
        int ch;
        ch = m_busy ? m_ch[m_pos / DWELL] : 0;
        check("sel",   32'(sel),   m_busy ? (32'd1 << ch) : 32'd0);
        check("idx",   32'(idx),   32'(ch));
        check("valid", 32'(valid), 32'(m_busy));
        check("busy",  32'(busy),  32'(m_busy));
        check("done",  32'(done),  32'(m_done));
        check("a",     32'(a),     32'(m_a));
`ifdef MUX_SEL_SCANNER_SWEEP_CNT_EN
        check("sweep", 32'(sweep_cnt), 32'(m_sweeps % 256));
`endif
    endtask

    task automatic cyc(input bit r, input bit s, input bit p,
                       input bit c, input logic [7:0] m, input bit d);
        rst = r; start = s; stop = p; cont = c; mask = m; data = d;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, $urandom_range(0, 1), 8'($urandom), i[0]);
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; cont = 0; mask = 0; data = 0;
        m_busy = 0; m_pos = 0; m_a = 0; m_done = 0; m_sweeps = 0;
        m_cont = 0;
        cyc(1, 0, 0, 0, 8'h00, 0);
        cyc(1, 1, 0, 1, 8'hFF, 1);
        // Full sweep, single shot
        cyc(0, 1, 0, 0, 8'hFF, 1);
        idle_run(36);
        // Sparse mask
        cyc(0, 1, 0, 0, 8'hA4, 0);
        idle_run(16);
        // Empty mask
        cyc(0, 1, 0, 0, 8'h00, 0);
        idle_run(3);
        // Start and stop together
        cyc(0, 1, 1, 0, 8'hFF, 0);
        idle_run(2);
        // Continuous, then stop mid-dwell
        cyc(0, 1, 0, 1, 8'h81, 1);
        idle_run(21);
        cyc(0, 0, 1, 1, 8'h81, 1);
        idle_run(3);
        // Reset mid-scan at channel 3, then restart
        cyc(0, 1, 0, 0, 8'hFF, 0);
        idle_run(13);
        cyc(1, 0, 0, 0, 8'hFF, 1);
        cyc(0, 1, 0, 0, 8'h3C, 1);
        idle_run(20);
        // Stop on the sweep-end cycle
        cyc(0, 1, 0, 1, 8'h02, 0);
        idle_run(DWELL - 1);
        cyc(0, 0, 1, 1, 8'h02, 0);
        idle_run(2);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] rm;
            rm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 1), rm, $urandom_range(0, 1));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
